dsp_slice_core: RTL and testbench
=================================

// Module: dsp_slice_core
// PURPOSE
//  Shared DSP48A1-style multiply/post-add engine serving all coefficient and Taylor calculators.
//  Clients OR their 92-bit requests onto dsp_ins_flat; the block returns 84-bit dsp_outs_flat.
//  Idle clients drive all zeros. One request per cycle; results return with fixed latency 2.
//  Arbitration is by program order in the clients; the engine itself is not aware of clients.
// PARAMETERS
//  CNT_W  16  width of saturating busy-cycle counter
// PORTS
//  clk            in   1      system clock, all state on rising edge
//  reset          in   1      asynchronous, active-low (0 = reset), sole reset
//  dsp_ins_flat   in   92     {opmode[91:84], a[83:66], b[65:48], c[47:0]}, a/b/c signed
//  dsp_outs_flat  out  84     {m[83:48] signed 36, p[47:0] signed 48}
//  stat_clr       in   1      synchronous clear of busy_cnt
//  busy_cnt       out  CNT_W  cycles with non-zero request, saturates at all-ones
// BEHAVIOUR
//  Opmode (globals.vh DSP_* macros): [1:0] X sel 00=0 01=M 10=P 11=D:A:B; [3:2] Z sel
//   00=0 01=0(no PCIN) 10=P 11=C; [4] pre-add en; [5] carry-in; [6] pre-sub; [7] post-sub.
//  Stage 1 (edge after issue cycle t): register opmode_r, a_r, b_r, c_r unconditionally.
//  Pre-adder: D fixed 0; b_eff = [4] ? ([6] ? -b_r : b_r) : b_r (18-bit wrap).
//  Stage 2 (edge end of t+1): m_r <= a_r*b_eff (36-bit signed, full precision);
//   p_r <= [7] ? Z - (X + cin) : Z + X + cin; 48-bit, two's-complement wrap, no saturation.
//  X=M uses combinational a_r*b_eff (same product as m_r gets); X=P / Z=P use current p_r
//   -> back-to-back X=M,Z=P requests accumulate.
//  X=D:A:B = {12'h000, a_r, b_eff} raw concatenation (no sign extension).
//  Outputs m=m_r, p=p_r: request issued in cycle t is visible throughout cycle t+2 and
//   holds until next edge; clients sample at end of t+2.
//  Multiplier always runs: opmode=NOP with a/b set still yields m (plain MUL requests).
//  opmode=0 -> p_r <= 0 (not hold); all-zero idle bus drives m=0, p=0 two cycles later.
//  Request overlap (ORed clients) is a client program error; engine computes on ORed value.
//  busy_cnt: +1 on each edge where stage-1 input bus != 0; stat_clr wins over increment;
//   holds at 2^CNT_W-1.
//  Reset (any time, incl. mid-accumulation): all stage regs, m_r, p_r, busy_cnt -> 0;
//   dsp_outs_flat = 0 immediately (async); in-flight requests discarded.
//  First request after reset release: normal latency 2, accumulation starts from p_r=0.
// CONFIGURATION
//  DSP_CARRYIN_EN defined: opmode[5] adds cin=1 at post-adder (rounding / 2's-compl negate).
//  Not defined: cin forced 0, opmode[5] ignored; all else identical.
// STRUCTURE
//  globals.vh: DSP_NOP, DSP_XIN_*, DSP_ZIN_*, DSP_PREADD_*, DSP_POSTADD_*, DSP_CARRYIN
//   opmode bit macros; field offsets for the 92/84-bit flat buses as localparam-free defines.
//  Single flat module; optional sub-module dsp_postadd (combinational X/Z mux + adder)
//   shared with any future second slice.
// TESTING
//  MUL: opmode=0, a=18'h10000, b=18'h08000 at t -> m=36'h0_8000_0000 (m[33:16]=18'h08000) at t+2.
//  SUB 1-r: opmode=XIN_DAB|ZIN_CIN|POSTADD_SUB, a=0, b=18'h10000, c=48'h04000
//   -> p=48'hFFFF_FFFF_4000 at t+2.
//  Accumulate: 4 back-to-back X=M,Z=P, a=b=18'h00100 -> p=1.00 step 48'h10000, 48'h40000 after 4th.
//  Pre-sub: opmode=PREADD_EN|PRESUB|XIN_M, a=18'h00002, b=18'h00003 -> m=-6, p=-6.
//  Carry-in: XIN_DAB|ZIN_CIN|SUB|CARRYIN, a=b=0, c=5 -> p=4 with DSP_CARRYIN_EN, 5 without.
//  Reset low mid-accumulation -> outputs 0 same cycle; busy_cnt=0; next MUL normal latency 2.
//  busy_cnt: 3 non-zero requests, stat_clr pulse with 4th -> busy_cnt=0 after that edge.

Source files
------------

// File: rtl/dsp_slice_core_pkg.sv
// Shared types, opmode encodings and arithmetic helpers for the DSP slice.
`default_nettype none

package dsp_slice_core_pkg;

  localparam int IN_W  = 92;
  localparam int OUT_W = 84;
  localparam int A_W   = 18;
  localparam int B_W   = 18;
  localparam int C_W   = 48;
  localparam int M_W   = 36;
  localparam int P_W   = 48;

  // Opmode encodings; clients OR these together to build a request.
  localparam logic [7:0] DSP_NOP         = 8'h00;
  localparam logic [7:0] DSP_XIN_ZERO    = 8'h00;
  localparam logic [7:0] DSP_XIN_M       = 8'h01;
  localparam logic [7:0] DSP_XIN_P       = 8'h02;
  localparam logic [7:0] DSP_XIN_DAB     = 8'h03;
  localparam logic [7:0] DSP_ZIN_ZERO    = 8'h00;
  localparam logic [7:0] DSP_ZIN_P       = 8'h08;
  localparam logic [7:0] DSP_ZIN_C       = 8'h0C;
  localparam logic [7:0] DSP_PREADD_EN   = 8'h10;
  localparam logic [7:0] DSP_CARRYIN     = 8'h20;
  localparam logic [7:0] DSP_PREADD_SUB  = 8'h40;
  localparam logic [7:0] DSP_POSTADD_SUB = 8'h80;

  typedef enum logic [1:0] {
    XSEL_ZERO = 2'b00,
    XSEL_M    = 2'b01,
    XSEL_P    = 2'b10,
    XSEL_DAB  = 2'b11
  } xsel_e;

  typedef enum logic [1:0] {
    ZSEL_ZERO  = 2'b00,
    ZSEL_PCIN  = 2'b01,
    ZSEL_P     = 2'b10,
    ZSEL_C     = 2'b11
  } zsel_e;

  typedef struct packed {
    logic [7:0]     opmode;
    logic [A_W-1:0] a;
    logic [B_W-1:0] b;
    logic [C_W-1:0] c;
  } dsp_req_t;

  function automatic logic [B_W-1:0] pre_b(input logic en, input logic sub,
                                           input logic [B_W-1:0] b);
    pre_b = (en && sub) ? (-b) : b;
  endfunction

  // Both operands sign-extended to full width so the truncated product is exact.
  function automatic logic [M_W-1:0] mul18s(input logic [A_W-1:0] a,
                                            input logic [B_W-1:0] b);
    logic [M_W-1:0] ax;
    logic [M_W-1:0] bx;
    ax = {{(M_W-A_W){a[A_W-1]}}, a};
    bx = {{(M_W-B_W){b[B_W-1]}}, b};
    mul18s = ax * bx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dsp_slice_core_postadd.sv
// Combinational X/Z operand mux and 48-bit post-adder/subtractor.
`default_nettype none

module dsp_slice_core_postadd
  import dsp_slice_core_pkg::*;
(
  input  logic           sub_i,
  input  logic           cin_i,
  input  xsel_e          x_sel_i,
  input  zsel_e          z_sel_i,
  input  logic [M_W-1:0] m_i,
  input  logic [P_W-1:0] p_i,
  input  logic [C_W-1:0] c_i,
  input  logic [M_W-1:0] dab_i,
  output logic [P_W-1:0] p_o
);

  logic [P_W-1:0] x_w;
  logic [P_W-1:0] z_w;
  logic [P_W-1:0] cin_w;

  always_comb begin
    x_w = '0;
    case (x_sel_i)
      XSEL_M:   x_w = {{(P_W-M_W){m_i[M_W-1]}}, m_i};
      XSEL_P:   x_w = p_i;
      XSEL_DAB: x_w = {{(P_W-M_W){1'b0}}, dab_i};
      default:  x_w = '0;
    endcase
  end

  // No cascade input exists, so the PCIN selection reads as zero.
  always_comb begin
    z_w = '0;
    case (z_sel_i)
      ZSEL_P:  z_w = p_i;
      ZSEL_C:  z_w = c_i;
      default: z_w = '0;
    endcase
  end

  assign cin_w = {{(P_W-1){1'b0}}, cin_i};
  assign p_o   = sub_i ? (z_w - (x_w + cin_w)) : (z_w + x_w + cin_w);

endmodule

`default_nettype wire

// File: rtl/dsp_slice_core.sv
// Two-stage multiply/post-add engine shared by all calculators; fixed latency 2.
// Optional: DSP_CARRYIN_EN enables opmode carry-in at the post-adder.
`default_nettype none

module dsp_slice_core
  import dsp_slice_core_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  dsp_ins_flat,
  output logic [OUT_W-1:0] dsp_outs_flat,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] busy_cnt
);

  dsp_req_t         req_q;
  logic [M_W-1:0]   m_q, m_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [CNT_W-1:0] busy_q, busy_d;
  logic [B_W-1:0]   b_eff;
  logic [M_W-1:0]   dab;
  logic             cin;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q  <= '0;
      m_q    <= '0;
      p_q    <= '0;
      busy_q <= '0;
    end else begin
      req_q  <= dsp_ins_flat;
      m_q    <= m_d;
      p_q    <= p_d;
      busy_q <= busy_d;
    end
  end

  assign b_eff = pre_b(req_q.opmode[4], req_q.opmode[6], req_q.b);
  assign m_d   = mul18s(req_q.a, b_eff);
  assign dab   = {req_q.a, b_eff};

`ifdef DSP_CARRYIN_EN
  assign cin = req_q.opmode[5];
`else
  logic unused_carry_bit;
  assign cin              = 1'b0;
  assign unused_carry_bit = req_q.opmode[5];
`endif

  dsp_slice_core_postadd u_postadd (
    .sub_i   (req_q.opmode[7]),
    .cin_i   (cin),
    .x_sel_i (xsel_e'(req_q.opmode[1:0])),
    .z_sel_i (zsel_e'(req_q.opmode[3:2])),
    .m_i     (m_d),
    .p_i     (p_q),
    .c_i     (req_q.c),
    .dab_i   (dab),
    .p_o     (p_d)
  );

  always_comb begin
    busy_d = busy_q;
    if (stat_clr) begin
      busy_d = '0;
    end else if ((dsp_ins_flat != '0) && !(&busy_q)) begin
      busy_d = busy_q + 1'b1;
    end
  end

  assign dsp_outs_flat = {m_q, p_q};
  assign busy_cnt      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_dsp_slice_core.sv
// Directed self-checking bench for dsp_slice_core.
`default_nettype none

module tb_dsp_slice_core;
  import dsp_slice_core_pkg::*;

  localparam int TB_CNT_W = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [91:0]         ins = '0;
  logic [83:0]         outs;
  logic                stat_clr = 1'b0;
  logic [TB_CNT_W-1:0] busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dsp_slice_core #(.CNT_W(TB_CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .dsp_ins_flat  (ins),
    .dsp_outs_flat (outs),
    .stat_clr      (stat_clr),
    .busy_cnt      (busy)
  );

  task automatic check_eq(input string tag, input logic [83:0] got, input logic [83:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [91:0] req(input logic [7:0] op, input logic [17:0] a,
                                      input logic [17:0] b, input logic [47:0] c);
    return {op, a, b, c};
  endfunction

  task automatic run_one(input string tag, input logic [7:0] op, input logic [17:0] a,
                         input logic [17:0] b, input logic [47:0] c,
                         input logic [35:0] exp_m, input logic [47:0] exp_p);
    @(negedge clk);
    ins = req(op, a, b, c);
    @(negedge clk);
    ins = '0;
    @(negedge clk);
    check_eq(tag, outs, {exp_m, exp_p});
  endtask

  logic [91:0] acc_req;
  logic [91:0] mul_req;
  logic [47:0] cin_exp;

  initial begin
    acc_req = req(DSP_XIN_M | DSP_ZIN_P, 18'h00100, 18'h00100, 48'h0);
    mul_req = req(DSP_NOP, 18'h10000, 18'h08000, 48'h0);
`ifdef DSP_CARRYIN_EN
    cin_exp = 48'h4;
`else
    cin_exp = 48'h5;
`endif

    #12;
    check_eq("rst_outs", outs, 84'h0);
    check_eq("rst_busy", {80'h0, busy}, 84'h0);
    @(negedge clk);
    reset = 1'b1;

    run_one("mul", DSP_NOP, 18'h10000, 18'h08000, 48'h0, 36'h0_8000_0000, 48'h0);
    check_eq("mul_m_hi", {66'h0, outs[81:64]}, {66'h0, 18'h08000});
    run_one("sub_1mr", DSP_XIN_DAB | DSP_ZIN_C | DSP_POSTADD_SUB, 18'h0, 18'h10000,
            48'h04000, 36'h0, 48'hFFFF_FFFF_4000);
    run_one("presub", DSP_PREADD_EN | DSP_PREADD_SUB | DSP_XIN_M, 18'h00002, 18'h00003,
            48'h0, 36'hF_FFFF_FFFA, 48'hFFFF_FFFF_FFFA);
    run_one("carryin", DSP_XIN_DAB | DSP_ZIN_C | DSP_POSTADD_SUB | DSP_CARRYIN,
            18'h0, 18'h0, 48'h5, 36'h0, cin_exp);
    run_one("dab_raw", DSP_XIN_DAB | DSP_PREADD_EN | DSP_PREADD_SUB, 18'h00001, 18'h00001,
            48'h0, 36'hF_FFFF_FFFF, 48'h0000_0007_FFFF);
    run_one("neg_sq", DSP_NOP, 18'h20000, 18'h20000, 48'h0, 36'h4_0000_0000, 48'h0);
    run_one("zsel_pcin", DSP_XIN_ZERO | 8'h04, 18'h0, 18'h0, 48'h123, 36'h0, 48'h0);

    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k >= 2) check_eq("accum", outs, {36'h0_0001_0000, 48'h10000 * (k - 1)});
      ins = (k < 4) ? acc_req : '0;
    end

    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 3) check_eq("pre_rst_p", {36'h0, outs[47:0]}, {36'h0, 48'h20000});
      ins = acc_req;
    end
    #2 reset = 1'b0;
    #1;
    check_eq("rst_async_outs", outs, 84'h0);
    check_eq("rst_async_busy", {80'h0, busy}, 84'h0);
    ins = '0;
    @(negedge clk);
    reset = 1'b1;

    @(negedge clk);
    ins = mul_req;
    @(negedge clk);
    ins = '0;
    check_eq("post_rst_lat1", outs, 84'h0);
    @(negedge clk);
    check_eq("post_rst_mul", outs, {36'h0_8000_0000, 48'h0});
    check_eq("busy_one", {80'h0, busy}, 84'h1);

    ins = mul_req;
    @(negedge clk);
    ins = mul_req;
    @(negedge clk);
    check_eq("busy_three", {80'h0, busy}, 84'h3);
    ins = mul_req;
    stat_clr = 1'b1;
    @(negedge clk);
    check_eq("busy_clr_wins", {80'h0, busy}, 84'h0);
    stat_clr = 1'b0;
    ins = '0;
    @(negedge clk);
    check_eq("busy_idle_hold", {80'h0, busy}, 84'h0);

    repeat (20) begin
      ins = mul_req;
      @(negedge clk);
    end
    ins = '0;
    check_eq("busy_saturate", {80'h0, busy}, 84'hF);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    check_eq("busy_sat_clr", {80'h0, busy}, 84'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
